// File: rtl/iterative_alu.sv
// Iterative ALU: bitwise, add/sub and compare ops finish in one cycle; MUL, DIVU
// and REMU iterate one bit per cycle over WIDTH cycles. A single operation is in flight.
module iterative_alu #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf,
  output logic             dz
);

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_SLT  = 4'd4;
  localparam logic [3:0] OP_SLTU = 4'd5;
  localparam logic [3:0] OP_NOR  = 4'd6;
  localparam logic [3:0] OP_MUL  = 4'd8;
  localparam logic [3:0] OP_DIVU = 4'd9;
  localparam logic [3:0] OP_REMU = 4'd10;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       op_r;
  logic [WIDTH-1:0] acc, x, y, b_r;

  logic [WIDTH-1:0] sum, dif, sc_res;
  logic             sc_ovf, multi;

  always_comb begin
    sum    = a + b;
    dif    = a - b;
    sc_res = '0;
    sc_ovf = 1'b0;
    multi  = (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
    case (op)
      OP_AND:  sc_res = a & b;
      OP_OR:   sc_res = a | b;
      OP_ADD: begin
        sc_res = sum;
        sc_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res = dif;
        sc_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT:  sc_res[0] = $signed(a) < $signed(b);
      OP_SLTU: sc_res[0] = a < b;
      OP_NOR:  sc_res = ~(a | b);
      default: sc_res = '0;
    endcase
  end

  // MUL: acc accumulates x (shifted multiplicand) under y[0] (shifted multiplier).
  // DIV: acc is the partial remainder, y shifts dividend bits out and quotient bits in.
  // b == 0 falls out naturally: every trial subtract succeeds, remainder ends as a.
  logic [WIDTH:0]   rem_sh;
  logic             ge;
  logic [WIDTH-1:0] mul_nx, rem_nx, quo_nx, fin_res;

  always_comb begin
    mul_nx = y[0] ? acc + x : acc;
    rem_sh = {acc, y[WIDTH-1]};
    ge     = rem_sh >= {1'b0, b_r};
    rem_nx = ge ? rem_sh[WIDTH-1:0] - b_r : rem_sh[WIDTH-1:0];
    quo_nx = {y[WIDTH-2:0], ge};
    case (op_r)
      OP_MUL:  fin_res = mul_nx;
      OP_DIVU: fin_res = quo_nx;
      default: fin_res = rem_nx;
    endcase
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = multi ? BUSY : DONE;
      end
      BUSY: if (cnt == CNT_W'(1)) state_nx = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      op_r   <= '0;
      acc    <= '0;
      x      <= '0;
      y      <= '0;
      b_r    <= '0;
      result <= '0;
      zero   <= 1'b0;
      ovf    <= 1'b0;
      dz     <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (in_valid) begin
          op_r <= op;
          b_r  <= b;
          if (multi) begin
            cnt <= CNT_W'(WIDTH);
            acc <= '0;
            x   <= a;
            y   <= (op == OP_MUL) ? b : a;
          end else begin
            result <= sc_res;
            zero   <= (sc_res == '0);
            ovf    <= sc_ovf;
            dz     <= 1'b0;
          end
        end
        BUSY: begin
          cnt <= cnt - CNT_W'(1);
          if (op_r == OP_MUL) begin
            acc <= mul_nx;
            x   <= x << 1;
            y   <= y >> 1;
          end else begin
            acc <= rem_nx;
            y   <= quo_nx;
          end
          if (cnt == CNT_W'(1)) begin
            result <= fin_res;
            zero   <= (fin_res == '0);
            ovf    <= 1'b0;
            dz     <= (op_r != OP_MUL) && (b_r == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iterative_alu.sv
// Self-checking bench for iterative_alu: directed vector table, multi-cycle corner
// sequences (backpressure, reset mid-operation) and random ops against a reference model.
module tb_iterative_alu;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready, zero, ovf, dz;
  logic [3:0]   op;
  logic [W-1:0] a, b, result;

  int checks = 0;
  int errors = 0;

  iterative_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .ovf(ovf), .dz(dz)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a, b;
    logic [W-1:0] res;
    logic         z, o, d;
  } vec_t;

  typedef struct {
    logic [W-1:0] res;
    logic         z, o, d;
    int           lat;
  } exp_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Reference: plain arithmetic from the operation definitions.
  function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] av, input logic [W-1:0] bv);
    exp_t e;
    longint s;
    logic [63:0] p;
    e.o = 1'b0; e.d = 1'b0; e.lat = 1; e.res = '0;
    case (o)
      4'd0: e.res = av & bv;
      4'd1: e.res = av | bv;
      4'd2: begin
        s = longint'($signed(av)) + longint'($signed(bv));
        e.res = av + bv;
        e.o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd3: begin
        s = longint'($signed(av)) - longint'($signed(bv));
        e.res = av - bv;
        e.o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd4: e.res = ($signed(av) < $signed(bv)) ? 32'd1 : 32'd0;
      4'd5: e.res = (av < bv) ? 32'd1 : 32'd0;
      4'd6: e.res = ~(av | bv);
      4'd8: begin
        p = {32'd0, av} * {32'd0, bv};
        e.res = p[W-1:0];
        e.lat = W + 1;
      end
      4'd9: begin
        e.res = (bv == 0) ? '1 : av / bv;
        e.d = (bv == 0);
        e.lat = W + 1;
      end
      4'd10: begin
        e.res = (bv == 0) ? av : av % bv;
        e.d = (bv == 0);
        e.lat = W + 1;
      end
      default: e.res = '0;
    endcase
    e.z = (e.res == 0);
    return e;
  endfunction

  // Starts at posedge+1 with the DUT idle; returns with the result taken (out_ready=1).
  task automatic do_op(input logic [3:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                       output exp_t got, output logic busy_ready);
    in_valid = 1'b1; op = o; a = av; b = bv;
    @(posedge clk); #1;
    in_valid = 1'b0; op = 4'($urandom); a = $urandom; b = $urandom;
    got.lat = 1;
    busy_ready = 1'b0;
    while (!out_valid && got.lat < 200) begin
      if (in_ready) busy_ready = 1'b1;
      @(posedge clk); #1;
      got.lat++;
    end
    got.res = result; got.z = zero; got.o = ovf; got.d = dz;
    @(posedge clk); #1;
  endtask

  task automatic run_check(input string tag, input logic [3:0] o, input logic [W-1:0] av,
                           input logic [W-1:0] bv, input exp_t e);
    exp_t got;
    logic br;
    do_op(o, av, bv, got, br);
    chk({tag, " result"}, 64'(got.res), 64'(e.res));
    chk({tag, " zero"}, 64'(got.z), 64'(e.z));
    chk({tag, " ovf"}, 64'(got.o), 64'(e.o));
    chk({tag, " dz"}, 64'(got.d), 64'(e.d));
    chk({tag, " latency"}, 64'(got.lat), 64'(e.lat));
    chk({tag, " in_ready low while busy"}, 64'(br), 64'(0));
  endtask

  vec_t vecs[$];

  initial begin
    exp_t e, got;
    logic br;
    logic [W-1:0] held;
    int seen;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = '0; a = '0; b = '0;

    vecs.push_back('{4'd2, 32'h7FFFFFFF, 32'd1,        32'h80000000, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{4'd3, 32'd5,        32'd5,        32'd0,        1'b1, 1'b0, 1'b0});
    vecs.push_back('{4'd4, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b0, 1'b0, 1'b0});
    vecs.push_back('{4'd5, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1, 1'b0, 1'b0});
    vecs.push_back('{4'd8, 32'h00010001, 32'h00010001, 32'h00020001, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{4'd9, 32'd100,      32'd7,        32'd14,       1'b0, 1'b0, 1'b0});
    vecs.push_back('{4'd10, 32'd100,     32'd7,        32'd2,        1'b0, 1'b0, 1'b0});
    vecs.push_back('{4'd9, 32'd9,        32'd0,        32'hFFFFFFFF, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{4'd10, 32'd9,       32'd0,        32'd9,        1'b0, 1'b0, 1'b1});
    vecs.push_back('{4'd0, 32'hF0F0FF00, 32'h0FF0F0F0, 32'h00F0F000, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{4'd1, 32'hF0000000, 32'h0000000F, 32'hF000000F, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{4'd6, 32'hFFFF0000, 32'h0000FFFF, 32'h00000000, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{4'd3, 32'h80000000, 32'd1,        32'h7FFFFFFF, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{4'd2, 32'h80000000, 32'h80000000, 32'd0,        1'b1, 1'b1, 1'b0});
    vecs.push_back('{4'd7, 32'd12,       32'd34,       32'd0,        1'b1, 1'b0, 1'b0});
    vecs.push_back('{4'd15, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,       1'b1, 1'b0, 1'b0});
    vecs.push_back('{4'd8, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        1'b0, 1'b0, 1'b0});
    vecs.push_back('{4'd4, 32'd1,        32'hFFFFFFFF, 32'd0,        1'b1, 1'b0, 1'b0});

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset in_ready", 64'(in_ready), 64'(1));
    chk("reset out_valid", 64'(out_valid), 64'(0));
    chk("reset result", 64'(result), 64'(0));
    chk("reset flags", 64'({zero, ovf, dz}), 64'(0));

    foreach (vecs[i]) begin
      e.res = vecs[i].res; e.z = vecs[i].z; e.o = vecs[i].o; e.d = vecs[i].d;
      e.lat = (vecs[i].op inside {4'd8, 4'd9, 4'd10}) ? W + 1 : 1;
      run_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, e);
    end

    // Backpressure: result held for 5 cycles while new requests are offered.
    out_ready = 1'b0;
    in_valid = 1'b1; op = 4'd8; a = 32'd1234; b = 32'd5678;
    @(posedge clk); #1;
    op = 4'd2; a = 32'd1; b = 32'd1;
    seen = 0;
    while (!out_valid && seen < 200) begin @(posedge clk); #1; seen++; end
    chk("bp out_valid reached", 64'(out_valid), 64'(1));
    held = result;
    chk("bp result", 64'(held), 64'(32'd7006652));
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("bp out_valid held", 64'(out_valid), 64'(1));
      chk("bp result stable", 64'(result), 64'(held));
      chk("bp in_ready low", 64'(in_ready), 64'(0));
    end
    out_ready = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    chk("bp idle after release", 64'({in_ready, out_valid}), 64'(2'b10));

    // Reset at BUSY cycle 10 of a DIVU discards it.
    in_valid = 1'b1; op = 4'd9; a = 32'd1000; b = 32'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    chk("rst busy still busy", 64'(in_ready), 64'(0));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst busy idle", 64'({in_ready, out_valid}), 64'(2'b10));
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("rst busy no out_valid", 64'(seen), 64'(0));
    e = model(4'd2, 32'd2, 32'd3);
    run_check("post-rst add", 4'd2, 32'd2, 32'd3, e);

    // Random ops against the model.
    for (int n = 0; n < 120; n++) begin
      logic [3:0] ro;
      logic [W-1:0] ra, rb;
      ro = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: rb = 32'($urandom_range(1, 20));
        2: ra = 32'($urandom_range(0, 100));
        3: rb = ra;
        default: ;
      endcase
      e = model(ro, ra, rb);
      do_op(ro, ra, rb, got, br);
      chk($sformatf("rand op%0d a=%0h b=%0h", ro, ra, rb),
          {got.res, 28'd0, got.z, got.o, got.d, br},
          {e.res, 28'd0, e.z, e.o, e.d, 1'b0});
      chk($sformatf("rand op%0d latency", ro), 64'(got.lat), 64'(e.lat));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/iterative_alu.md
ITERATIVE_ALU -- requirements
Module: iterative_alu

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, operand/result width in bits (legal range 4..64).
REQ-002 SHALL provide parameter CNT_W, default $clog2(WIDTH+1), iteration counter width (derived, not overridden).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  operation request present.
REQ-006 in_ready  output  1  block accepts a request this cycle.
REQ-007 op  input  4  operation select: 0 AND, 1 OR, 2 ADD, 3 SUB, 4 SLT, 5 SLTU, 6 NOR, 8 MUL, 9 DIVU, 10 REMU; others reserved.
REQ-008 a, b  input  WIDTH each  operands.
REQ-009 out_valid  output  1  result present.
REQ-010 out_ready  input  1  consumer takes result this cycle.
REQ-011 result  output  WIDTH  operation result.
REQ-012 zero  output  1  high when result == 0.
REQ-013 ovf  output  1  signed overflow of ADD/SUB; 0 for all other ops.
REQ-014 dz  output  1  high when DIVU/REMU had b == 0.

Function
REQ-015 SHALL implement FSM with states IDLE, BUSY, DONE; in_ready = (state == IDLE); out_valid = (state == DONE).
REQ-016 Request accepted when in_valid && in_ready; a, b, op registered at acceptance; later input changes ignored.
REQ-017 Single-cycle ops (0-6, reserved): IDLE -> DONE on acceptance; out_valid high the cycle after acceptance.
REQ-018 Multi-cycle ops (8-10): IDLE -> BUSY on acceptance; counter loaded with WIDTH, decremented each BUSY cycle; BUSY -> DONE when counter reaches 1; out_valid first high WIDTH+1 cycles after acceptance.
REQ-019 DONE -> IDLE when out_ready; result, zero, ovf, dz held stable while out_valid && !out_ready.
REQ-020 No request accepted in BUSY or DONE (one operation in flight).
REQ-021 AND/OR/NOR bitwise; ADD/SUB modulo 2^WIDTH; ovf = operands' signs equal (ADD) or differ (SUB) and result sign differs from a.
REQ-022 SLT: result = 1 if signed a < signed b else 0; SLTU unsigned compare; upper bits 0.
REQ-023 MUL: shift-add, one partial product per BUSY cycle; result = low WIDTH bits of a*b (unsigned).
REQ-024 DIVU/REMU: restoring division, one quotient bit per BUSY cycle; DIVU result = floor(a/b), REMU result = a mod b.
REQ-025 b == 0: DIVU result all ones, REMU result = a, dz = 1; full WIDTH-cycle latency still applies.
REQ-026 Reserved op: result 0, zero 1, ovf 0, dz 0, single-cycle timing.
REQ-027 zero, ovf, dz registered together with result; all three valid only when out_valid.

Reset
REQ-028 rst high at a clock edge: state -> IDLE, counter 0, result 0, zero 0, ovf 0, dz 0, out_valid 0, in_ready 1 on next cycle.
REQ-029 rst in BUSY or DONE discards the operation; no out_valid is produced for it.
REQ-030 rst takes priority over in_valid and out_ready in the same cycle.

Verification
REQ-031 WIDTH=32, ADD a=0x7FFFFFFF b=1, out_ready=1 -> out_valid 1 cycle later, result 0x80000000, ovf 1, zero 0.
REQ-032 SUB a=5 b=5 -> result 0, zero 1, ovf 0; SLT a=0xFFFFFFFF b=1 -> 1; SLTU same operands -> 0.
REQ-033 MUL a=0x10001 b=0x10001 -> in_ready 0 for 33 cycles, out_valid at cycle 33 after accept, result 0x00020001.
REQ-034 DIVU a=100 b=7 -> 14; REMU a=100 b=7 -> 2; DIVU a=9 b=0 -> 0xFFFFFFFF, dz 1; REMU a=9 b=0 -> 9, dz 1.
REQ-035 Backpressure: out_ready low 5 cycles in DONE -> result/flags stable, in_valid ignored, IDLE one cycle after out_ready rises.
REQ-036 rst asserted at BUSY cycle 10 of DIVU -> IDLE next cycle, no out_valid, next ADD 2+3 returns 5.
